// File: rtl/im_port_arbiter_if.sv
// Bundle between the fetch/debug requesters, the port arbiter and the instruction memory.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface im_port_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_flush;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;

    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] im_addr;
    logic [31:0] im_data;

    modport slave (
        input  f_req, f_addr, f_flush,
        input  d_req, d_addr,
        input  im_data,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output im_addr
    );

    modport master (
        output f_req, f_addr, f_flush,
        output d_req, d_addr,
        output im_data,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  im_addr
    );
endinterface

// File: rtl/im_port_arbiter.sv
// Shares the asynchronous-read instruction memory port between fetch (F) and debug (D).
// Fetch has priority; a burst counter guarantees D a slot after FETCH_BURST contended F grants.
//
//   owner      | meaning
//   -----------+-----------------------------------------------------------
//   OWN_NONE   | no grant last cycle; no response this cycle
//   OWN_FETCH  | F was granted last cycle; im_data belongs to F this cycle
//   OWN_DEBUG  | D was granted last cycle; im_data belongs to D this cycle
module im_port_arbiter #(
    parameter int DEPTH       = 128,
    parameter int FETCH_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    im_port_arbiter_if.slave    bus
);

    localparam int               CNT_W      = $clog2(FETCH_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(FETCH_BURST);
    localparam logic [31:0]      ADDR_LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DEBUG = 2'd2
    } owner_t;

    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             err_q, err_d;

    logic             f_gnt, d_gnt;
    logic             burst_full;
    logic             f_live, d_live;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        burst_full = (cnt_q == CNT_MAX);
        d_gnt      = ~reset & bus.d_req & (~bus.f_req | burst_full);
        f_gnt      = ~reset & bus.f_req & ~d_gnt;

        owner_d = OWN_NONE;
        addr_d  = addr_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (d_gnt) begin
            owner_d = OWN_DEBUG;
            addr_d  = bus.d_addr;
            err_d   = addr_bad(bus.d_addr);
        end else if (f_gnt) begin
            owner_d = OWN_FETCH;
            addr_d  = bus.f_addr;
            err_d   = addr_bad(bus.f_addr);
        end

        // The count only measures F grants that actually held D off.
        if (d_gnt || !bus.d_req) begin
            cnt_d = '0;
        end else if (f_gnt && !burst_full) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Responses are gated by reset so an in-flight word is dropped immediately.
    assign f_live = ~reset & (owner_q == OWN_FETCH) & ~bus.f_flush;
    assign d_live = ~reset & (owner_q == OWN_DEBUG);

    assign bus.f_gnt    = f_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.im_addr  = addr_q;

    assign bus.f_rvalid = f_live;
    assign bus.f_err    = f_live & err_q;
    assign bus.f_rdata  = (f_live && !err_q) ? bus.im_data : 32'h0;

    assign bus.d_rvalid = d_live;
    assign bus.d_err    = d_live & err_q;
    assign bus.d_rdata  = (d_live && !err_q) ? bus.im_data : 32'h0;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a behavioural asynchronous-read instruction memory.
module tb_im_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   fails     = 0;

    always #5 clk = ~clk;

    im_port_arbiter_if bus();

    im_port_arbiter #(.DEPTH(128), .FETCH_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] memw(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0011);
    endfunction

    // Out-of-range reads return a recognisable junk pattern that must never reach a requester.
    assign bus.im_data = (bus.im_addr < 32'd512) ? memw(int'(bus.im_addr[8:2])) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.f_req   = 1'b0;
        bus.f_addr  = 32'h0;
        bus.f_flush = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_addr  = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.f_req = 1'b1; bus.d_req = 1'b1; bus.f_addr = 32'h4; bus.d_addr = 32'h8;
        tick(); tick();
        settle();
        tests_run++; if (bus.f_gnt !== 1'b0) begin fails++; $display("FAIL reset_f_gnt: got %b want 0", bus.f_gnt); end
        tests_run++; if (bus.d_gnt !== 1'b0) begin fails++; $display("FAIL reset_d_gnt: got %b want 0", bus.d_gnt); end
        tests_run++; if (bus.im_addr !== 32'h0) begin fails++; $display("FAIL reset_im_addr: got %h want 0", bus.im_addr); end
        tests_run++; if ({bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err} !== 4'b0) begin fails++; $display("FAIL reset_valid_err: got %b want 0000", {bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err}); end
        tests_run++; if ({bus.f_rdata, bus.d_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h/%h want 0", bus.f_rdata, bus.d_rdata); end
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only();
        for (int i = 0; i < 4; i++) begin
            bus.f_req  = (i < 3);
            bus.f_addr = 32'(4 * i);
            settle();
            tests_run++; if (bus.f_gnt !== (i < 3)) begin fails++; $display("FAIL fonly_f_gnt c%0d: got %b want %b", i, bus.f_gnt, (i < 3)); end
            tests_run++; if (bus.d_gnt !== 1'b0 || bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL fonly_d_idle c%0d: got gnt=%b rvalid=%b want 0", i, bus.d_gnt, bus.d_rvalid); end
            if (i > 0) begin
                tests_run++; if (bus.f_rvalid !== 1'b1 || bus.f_err !== 1'b0) begin fails++; $display("FAIL fonly_rvalid c%0d: got rvalid=%b err=%b want 1/0", i, bus.f_rvalid, bus.f_err); end
                tests_run++; if (bus.f_rdata !== memw(i - 1)) begin fails++; $display("FAIL fonly_rdata c%0d: got %h want %h", i, bus.f_rdata, memw(i - 1)); end
            end
            tick();
        end
        settle();
        tests_run++; if (bus.f_rvalid !== 1'b0) begin fails++; $display("FAIL fonly_drain: got rvalid=%b want 0", bus.f_rvalid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_contention();
        logic prev_d, exp_d;
        prev_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.f_req = 1'b1; bus.f_addr = 32'h20;
            bus.d_req = 1'b1; bus.d_addr = 32'h44;
            exp_d = ((i % 5) == 4);
            settle();
            tests_run++; if (bus.d_gnt !== exp_d || bus.f_gnt !== !exp_d) begin fails++; $display("FAIL contention_gnt c%0d: got f=%b d=%b want f=%b d=%b", i, bus.f_gnt, bus.d_gnt, !exp_d, exp_d); end
            if (i > 0) begin
                tests_run++; if (bus.d_rvalid !== prev_d || bus.f_rvalid !== !prev_d) begin fails++; $display("FAIL contention_rvalid c%0d: got f=%b d=%b want f=%b d=%b", i, bus.f_rvalid, bus.d_rvalid, !prev_d, prev_d); end
                tests_run++; if ((prev_d ? bus.d_rdata : bus.f_rdata) !== (prev_d ? memw(17) : memw(8))) begin fails++; $display("FAIL contention_rdata c%0d: got f=%h d=%h", i, bus.f_rdata, bus.d_rdata); end
            end
            prev_d = exp_d;
            tick();
        end
        idle_inputs();
        settle();
        tests_run++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== memw(17)) begin fails++; $display("FAIL contention_last_d: got rvalid=%b data=%h want 1/%h", bus.d_rvalid, bus.d_rdata, memw(17)); end
        tick();
    endtask

    task automatic test_cnt_clear();
        bit dr[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        bit ed[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            bus.f_req = 1'b1; bus.f_addr = 32'h30;
            bus.d_req = dr[i]; bus.d_addr = 32'h50;
            settle();
            tests_run++; if (bus.d_gnt !== ed[i] || bus.f_gnt !== !ed[i]) begin fails++; $display("FAIL cnt_clear_gnt c%0d: got f=%b d=%b want d=%b", i, bus.f_gnt, bus.d_gnt, ed[i]); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_debug_only();
        bus.d_req = 1'b1; bus.d_addr = 32'h1FC;
        settle();
        tests_run++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL donly_gnt_last: got %b want 1", bus.d_gnt); end
        tick();
        bus.d_addr = 32'h200;
        settle();
        tests_run++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL donly_gnt_oor: got %b want 1", bus.d_gnt); end
        tests_run++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== memw(127)) begin fails++; $display("FAIL donly_last_word: got v=%b e=%b d=%h want 1/0/%h", bus.d_rvalid, bus.d_err, bus.d_rdata, memw(127)); end
        tick();
        bus.d_req = 1'b0;
        settle();
        tests_run++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin fails++; $display("FAIL donly_oor: got v=%b e=%b d=%h want 1/1/0", bus.d_rvalid, bus.d_err, bus.d_rdata); end
        tests_run++; if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 32'h0) begin fails++; $display("FAIL donly_f_idle: got v=%b d=%h want 0/0", bus.f_rvalid, bus.f_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        bus.f_req = 1'b1; bus.f_addr = 32'h6;
        settle();
        tests_run++; if (bus.f_gnt !== 1'b1) begin fails++; $display("FAIL misalign_gnt: got %b want 1", bus.f_gnt); end
        tick();
        bus.f_req = 1'b0;
        settle();
        tests_run++; if (bus.f_rvalid !== 1'b1 || bus.f_err !== 1'b1 || bus.f_rdata !== 32'h0) begin fails++; $display("FAIL misalign_resp: got v=%b e=%b d=%h want 1/1/0", bus.f_rvalid, bus.f_err, bus.f_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        settle();
        tests_run++; if (bus.f_gnt !== 1'b1) begin fails++; $display("FAIL flush_first_gnt: got %b want 1", bus.f_gnt); end
        tick();
        bus.f_flush = 1'b1; bus.f_addr = 32'h10;
        settle();
        tests_run++; if (bus.f_rvalid !== 1'b0 || bus.f_err !== 1'b0) begin fails++; $display("FAIL flush_suppress: got v=%b e=%b want 0/0", bus.f_rvalid, bus.f_err); end
        tests_run++; if (bus.f_gnt !== 1'b1) begin fails++; $display("FAIL flush_new_gnt: got %b want 1", bus.f_gnt); end
        tick();
        bus.f_flush = 1'b0; bus.f_req = 1'b0;
        settle();
        tests_run++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== memw(4)) begin fails++; $display("FAIL flush_next_resp: got v=%b d=%h want 1/%h", bus.f_rvalid, bus.f_rdata, memw(4)); end
        tick();
        bus.d_req = 1'b1; bus.d_addr = 32'h1FC;
        tick();
        bus.d_req = 1'b0; bus.f_flush = 1'b1;
        settle();
        tests_run++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== memw(127)) begin fails++; $display("FAIL flush_ignores_d: got v=%b d=%h want 1/%h", bus.d_rvalid, bus.d_rdata, memw(127)); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        bus.f_req = 1'b1; bus.f_addr = 32'hC;
        tick();
        bus.f_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 32'h8;
        settle();
        tests_run++; if (bus.d_gnt !== 1'b1 || bus.f_rvalid !== 1'b1 || bus.f_rdata !== memw(3)) begin fails++; $display("FAIL b2b_f_then_d: got dg=%b fv=%b fd=%h want 1/1/%h", bus.d_gnt, bus.f_rvalid, bus.f_rdata, memw(3)); end
        tick();
        bus.d_req = 1'b0;
        settle();
        tests_run++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== memw(2) || bus.f_rvalid !== 1'b0) begin fails++; $display("FAIL b2b_d_resp: got dv=%b dd=%h fv=%b want 1/%h/0", bus.d_rvalid, bus.d_rdata, bus.f_rvalid, memw(2)); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midop();
        bus.d_req = 1'b1; bus.d_addr = 32'h40;
        settle();
        tests_run++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL midrst_d_gnt: got %b want 1", bus.d_gnt); end
        tick();
        bus.d_req = 1'b0; reset = 1'b1;
        settle();
        tests_run++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin fails++; $display("FAIL midrst_d_drop: got v=%b d=%h want 0/0", bus.d_rvalid, bus.d_rdata); end
        tick();
        settle();
        tests_run++; if (bus.im_addr !== 32'h0) begin fails++; $display("FAIL midrst_im_addr: got %h want 0", bus.im_addr); end
        reset = 1'b0;
        tick();
        // Charge the burst counter to 3, then reset while both requests stay up.
        for (int i = 0; i < 3; i++) begin
            bus.f_req = 1'b1; bus.f_addr = 32'h24; bus.d_req = 1'b1; bus.d_addr = 32'h48;
            tick();
        end
        reset = 1'b1;
        settle();
        tests_run++; if ({bus.f_gnt, bus.d_gnt, bus.f_rvalid} !== 3'b000) begin fails++; $display("FAIL midrst_contend_hold: got fg/dg/fv=%b want 000", {bus.f_gnt, bus.d_gnt, bus.f_rvalid}); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            tests_run++; if (bus.d_gnt !== (i == 4) || bus.f_gnt !== (i != 4)) begin fails++; $display("FAIL midrst_restart c%0d: got f=%b d=%b want d=%b", i, bus.f_gnt, bus.d_gnt, (i == 4)); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_contention();
        test_cnt_clear();
        test_debug_only();
        test_misaligned();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
